// File: rtl/debug_host_controller.sv
// Host-side bridge between a UART pair and the processor's wait/debug port.
// Decodes single-byte commands, performs register reads and continue pulses,
// and streams replies back one byte at a time, LSB byte first.
module debug_host_controller #(
  parameter int WORD_SIZE    = 18,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  input  logic                 wait_for_continue,
  output logic                 wait_continue_execution,
  output logic                 debug_get_param,
  output logic [3:0]           debug_reg_addr,
  input  logic [WORD_SIZE-1:0] debug_data_out,
  output logic                 cmd_dropped
);

  localparam int NB = (WORD_SIZE + 7) / 8;
  localparam int RW = 8 * NB;
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int BW = $clog2(NB + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONT,
    S_REG_READ,
    S_SEND,
    S_TX_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   reply_q, reply_d;
  logic [BW-1:0]   bytes_left_q, bytes_left_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            skip_q, skip_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            cont_q, cont_d;
  logic            get_param_q, get_param_d;
  logic [3:0]      reg_addr_q, reg_addr_d;
  logic            dropped_q, dropped_d;

  assign tx_data                 = tx_data_q;
  assign tx_start                = tx_start_q;
  assign wait_continue_execution = cont_q;
  assign debug_get_param         = get_param_q;
  assign debug_reg_addr          = reg_addr_q;
  assign cmd_dropped             = dropped_q;

  // Next-state and registered-output logic for the command/reply sequencer.
  always_comb begin
    state_d      = state_q;
    reply_d      = reply_q;
    bytes_left_d = bytes_left_q;
    cnt_d        = cnt_q;
    skip_d       = 1'b0;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    cont_d       = 1'b0;
    get_param_d  = get_param_q;
    reg_addr_d   = reg_addr_q;
    dropped_d    = dropped_q;

    if (rx_valid && (state_q != S_IDLE)) begin
      dropped_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          reply_d      = '0;
          bytes_left_d = BW'(1);
          state_d      = S_SEND;
          if (rx_data == 8'h01) begin
            reply_d[7:0] = {7'b0, wait_for_continue};
          end else if (rx_data == 8'h02) begin
            if (wait_for_continue) begin
              cont_d       = 1'b1;
              reply_d[7:0] = 8'hAA;
              state_d      = S_CONT;
            end else begin
              reply_d[7:0] = 8'hEE;
            end
          end else if ((rx_data[7:4] == 4'h1) && (rx_data[3:0] <= 4'd8)) begin
            if (wait_for_continue) begin
              reg_addr_d  = rx_data[3:0];
              get_param_d = 1'b1;
              cnt_d       = '0;
              state_d     = S_REG_READ;
            end else begin
              reply_d[7:0] = 8'hEE;
            end
          end else begin
            reply_d[7:0] = 8'hEE;
          end
        end
      end

      S_CONT: begin
        state_d = S_SEND;
      end

      S_REG_READ: begin
        if (cnt_q == CW'(READ_LATENCY - 1)) begin
          reply_d                  = '0;
          reply_d[WORD_SIZE-1:0]   = debug_data_out;
          bytes_left_d             = BW'(NB);
          get_param_d              = 1'b0;
          state_d                  = S_SEND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_SEND: begin
        if (!tx_busy) begin
          tx_start_d   = 1'b1;
          tx_data_d    = reply_q[7:0];
          reply_d      = reply_q >> 8;
          bytes_left_d = bytes_left_q - BW'(1);
          skip_d       = 1'b1;
          state_d      = S_TX_WAIT;
        end
      end

      S_TX_WAIT: begin
        if (!skip_q && !tx_busy) begin
          state_d = (bytes_left_q == '0) ? S_IDLE : S_SEND;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset to the idle values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      reply_q      <= '0;
      bytes_left_q <= '0;
      cnt_q        <= '0;
      skip_q       <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      cont_q       <= 1'b0;
      get_param_q  <= 1'b0;
      reg_addr_q   <= 4'h0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      reply_q      <= reply_d;
      bytes_left_q <= bytes_left_d;
      cnt_q        <= cnt_d;
      skip_q       <= skip_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      cont_q       <= cont_d;
      get_param_q  <= get_param_d;
      reg_addr_q   <= reg_addr_d;
      dropped_q    <= dropped_d;
    end
  end

endmodule

// File: tb/tb_debug_host_controller.sv
// Testbench for debug_host_controller: a UART transmitter model, a monitor
// and a command-level reference model of the expected replies.
module tb_debug_host_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        wait_for_continue;
  logic        wait_continue_execution;
  logic        debug_get_param;
  logic [3:0]  debug_reg_addr;
  logic [17:0] debug_data_out;
  logic        cmd_dropped;

  int n_cmp = 0;
  int n_mis = 0;

  int   busy_cnt  = 0;
  int   busy_len  = 1;
  bit   hold_busy = 1'b0;
  int   cyc       = 0;
  logic [7:0] tx_q[$];
  int   start_cyc_q[$];
  int   cont_cycles     = 0;
  int   gp_cycles       = 0;
  int   start_busy_viol = 0;
  int   cont_gp_viol    = 0;

  int   base_q, base_cont, base_gp, cmd_cyc;
  logic [7:0] exp_bytes[3];
  int   exp_n, exp_pulse, exp_gp;

  assign tx_busy = (busy_cnt > 0) || hold_busy;

  debug_host_controller #(.WORD_SIZE(18), .READ_LATENCY(2)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .rx_data                 (rx_data),
    .rx_valid                (rx_valid),
    .tx_data                 (tx_data),
    .tx_start                (tx_start),
    .tx_busy                 (tx_busy),
    .wait_for_continue       (wait_for_continue),
    .wait_continue_execution (wait_continue_execution),
    .debug_get_param         (debug_get_param),
    .debug_reg_addr          (debug_reg_addr),
    .debug_data_out          (debug_data_out),
    .cmd_dropped             (cmd_dropped)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Cycle counter advanced on each active edge.
  always @(posedge clock) cyc++;

  // Transmitter model and monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (tx_start) begin
      if (tx_busy) start_busy_viol++;
      tx_q.push_back(tx_data);
      start_cyc_q.push_back(cyc);
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    if (wait_continue_execution) begin
      cont_cycles++;
      if (debug_get_param) cont_gp_viol++;
    end
    if (debug_get_param) gp_cycles++;
  end

  // Runaway guard.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Command-level reference: what the host must reply and do for one command.
  task automatic model(input logic [7:0] cmd, input bit w, input logic [17:0] d);
    logic [31:0] dd;
    dd        = 32'(d);
    exp_n     = 1;
    exp_pulse = 0;
    exp_gp    = 0;
    exp_bytes[0] = 8'hEE;
    exp_bytes[1] = 8'h00;
    exp_bytes[2] = 8'h00;
    if (cmd == 8'h01) begin
      exp_bytes[0] = w ? 8'h01 : 8'h00;
    end else if (cmd == 8'h02) begin
      if (w) begin
        exp_pulse    = 1;
        exp_bytes[0] = 8'hAA;
      end
    end else if (cmd >= 8'h10 && cmd <= 8'h18 && w) begin
      exp_n  = 3;
      exp_gp = 2;
      for (int i = 0; i < 3; i++) exp_bytes[i] = dd[8*i +: 8];
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] cmd);
    @(negedge clock);
    base_q    = tx_q.size();
    base_cont = cont_cycles;
    base_gp   = gp_cycles;
    cmd_cyc   = cyc;
    rx_data   = cmd;
    rx_valid  = 1'b1;
    @(negedge clock);
    rx_valid  = 1'b0;
  endtask

  task automatic collect(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      #2;
      if ((tx_q.size() - base_q) >= exp_n && !tx_busy) begin
        done = 1'b1;
        break;
      end
    end
    check_output({tag, " completed"}, 32'(done), 32'd1);
    repeat (6) @(negedge clock);
    #2;
    check_output({tag, " byte count"}, 32'(tx_q.size() - base_q), 32'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      if (base_q + i < tx_q.size())
        check_output($sformatf("%s byte%0d", tag, i), 32'(tx_q[base_q + i]), 32'(exp_bytes[i]));
    end
    check_output({tag, " continue cycles"}, 32'(cont_cycles - base_cont), 32'(exp_pulse));
    check_output({tag, " get_param cycles"}, 32'(gp_cycles - base_gp), 32'(exp_gp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " tx_data"},   32'(tx_data), 32'd0);
    check_output({tag, " tx_start"},  32'(tx_start), 32'd0);
    check_output({tag, " continue"},  32'(wait_continue_execution), 32'd0);
    check_output({tag, " get_param"}, 32'(debug_get_param), 32'd0);
    check_output({tag, " reg_addr"},  32'(debug_reg_addr), 32'd0);
    check_output({tag, " dropped"},   32'(cmd_dropped), 32'd0);
  endtask

  // Directed scenarios followed by a randomized command sweep.
  initial begin
    logic [7:0]  cmd;
    logic [17:0] data;
    bit          w;
    int          sz;
    bit          seen;

    reset             = 1'b1;
    rx_data           = 8'h00;
    rx_valid          = 1'b0;
    wait_for_continue = 1'b0;
    debug_data_out    = 18'h0;
    #12;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b0;

    // STATUS while running, with latency check.
    busy_len = 3;
    model(8'h01, 1'b0, 18'h0);
    apply_stimulus(8'h01);
    collect("status0");
    if (tx_q.size() > base_q)
      check_output("status latency", 32'(start_cyc_q[base_q] - cmd_cyc), 32'd2);
    check_output("status0 reg_addr", 32'(debug_reg_addr), 32'd0);
    check_output("status0 dropped", 32'(cmd_dropped), 32'd0);

    // STATUS while waiting.
    wait_for_continue = 1'b1;
    model(8'h01, 1'b1, 18'h0);
    apply_stimulus(8'h01);
    collect("status1");

    // Register read of r3.
    debug_data_out = 18'h2ABCD;
    model(8'h13, 1'b1, 18'h2ABCD);
    apply_stimulus(8'h13);
    collect("read r3");
    check_output("read r3 reg_addr", 32'(debug_reg_addr), 32'd3);

    // CONTINUE while waiting and while running.
    model(8'h02, 1'b1, 18'h0);
    apply_stimulus(8'h02);
    collect("cont waiting");
    wait_for_continue = 1'b0;
    model(8'h02, 1'b0, 18'h0);
    apply_stimulus(8'h02);
    collect("cont running");

    // READ ip while running and an unknown opcode.
    model(8'h18, 1'b0, 18'h0);
    apply_stimulus(8'h18);
    collect("read ip running");
    model(8'h7F, 1'b0, 18'h0);
    apply_stimulus(8'h7F);
    collect("unknown 7f");

    // Command arriving while the transmitter is already busy.
    hold_busy = 1'b1;
    model(8'h01, 1'b0, 18'h0);
    apply_stimulus(8'h01);
    repeat (8) @(negedge clock);
    #2;
    check_output("stalled no byte", 32'(tx_q.size() - base_q), 32'd0);
    hold_busy = 1'b0;
    collect("busy status");

    // Slow transmitter with a byte injected mid-reply.
    wait_for_continue = 1'b1;
    busy_len          = 10;
    debug_data_out    = 18'h1F00D;
    model(8'h15, 1'b1, 18'h1F00D);
    apply_stimulus(8'h15);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      #2;
      if (tx_q.size() > base_q) seen = 1'b1;
    end
    check_output("inject first byte seen", 32'(seen), 32'd1);
    @(negedge clock);
    rx_data  = 8'h01;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
    collect("slow read");
    check_output("slow read dropped", 32'(cmd_dropped), 32'd1);

    // Randomized commands against the reference model.
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 3))
        0:       cmd = 8'h01;
        1:       cmd = 8'h02;
        2:       cmd = 8'h10 + 8'($urandom_range(0, 8));
        default: cmd = 8'($urandom);
      endcase
      w    = 1'($urandom_range(0, 1));
      data = 18'($urandom);
      @(negedge clock);
      wait_for_continue = w;
      debug_data_out    = data;
      busy_len          = $urandom_range(1, 6);
      model(cmd, w, data);
      apply_stimulus(cmd);
      collect($sformatf("rand%0d cmd%02h w%0d", it, cmd, w));
      if (exp_gp != 0)
        check_output($sformatf("rand%0d reg_addr", it), 32'(debug_reg_addr), 32'(cmd[3:0]));
    end
    check_output("dropped sticky", 32'(cmd_dropped), 32'd1);

    // Reset in the middle of a register reply.
    wait_for_continue = 1'b1;
    busy_len          = 4;
    debug_data_out    = 18'h3C3C3;
    apply_stimulus(8'h15);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      #2;
      if (tx_q.size() > base_q) seen = 1'b1;
    end
    check_output("midreset first byte seen", 32'(seen), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    sz = tx_q.size();
    repeat (30) @(negedge clock);
    #2;
    check_output("midreset no more bytes", 32'(tx_q.size() - sz), 32'd0);

    wait_for_continue = 1'b0;
    model(8'h01, 1'b0, 18'h0);
    apply_stimulus(8'h01);
    collect("post reset status");

    check_output("tx_start while busy", 32'(start_busy_viol), 32'd0);
    check_output("continue with get_param", 32'(cont_gp_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/debug_host_controller.md
Name: debug_host_controller

Overview:
- Host-side counterpart of the processor's wait/debug interface.
- Receives command bytes from a UART receiver and drives `wait_continue_execution`, `debug_get_param` and `debug_reg_addr`.
- Captures `debug_data_out` and returns replies as bytes to a UART transmitter.
- Sits between the UART pair and `processor_staged` in the FPGA top level.

Parameters:
- WORD_SIZE, 18: width of processor registers/ip and of `debug_data_out`.
- READ_LATENCY, 2: cycles `debug_get_param` is held before `debug_data_out` is sampled (≥1).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high; forces all state and outputs to reset values.
- rx_data  input  8  received command byte.
- rx_valid  input  1  one-cycle strobe, rx_data valid.
- tx_data  output  8  reply byte; stable while tx_start=1.
- tx_start  output  1  one-cycle request to transmit tx_data.
- tx_busy  input  1  transmitter busy; rises no later than the cycle after tx_start.
- wait_for_continue  input  1  processor stopped on wait instruction.
- wait_continue_execution  output  1  one-cycle continue pulse to processor.
- debug_get_param  output  1  freezes processor, selects debug read path.
- debug_reg_addr  output  4  0..7 = r0..r7, 8 = ip.
- debug_data_out  input  WORD_SIZE  value of selected register.
- cmd_dropped  output  1  sticky; set when an rx byte arrives while not IDLE.

Behaviour:
- Reset values: tx_data=0, tx_start=0, wait_continue_execution=0, debug_get_param=0, debug_reg_addr=0, cmd_dropped=0, state=IDLE.
- Command decode happens in IDLE on rx_valid=1:
  - 0x01 STATUS: reply 1 byte; 0x01 if wait_for_continue=1, else 0x00.
  - 0x02 CONTINUE: if wait_for_continue=1, state CONT drives wait_continue_execution=1 for exactly one cycle, then reply 0xAA. If not waiting, no pulse; reply 0xEE.
  - 0x10..0x18 READ_REG n=byte[3:0]: if wait_for_continue=1, go to REG_READ; otherwise reply 0xEE.
  - Any other byte: reply 0xEE.
- REG_READ:
  - debug_reg_addr=n and debug_get_param=1 from the cycle after decode.
  - A counter runs READ_LATENCY cycles; on the last cycle debug_data_out is latched into a shift register (zero-extended to 8*NB bits, NB=ceil(WORD_SIZE/8), =3 for 18).
  - debug_get_param returns to 0 the cycle after capture; debug_reg_addr holds its value.
- SEND:
  - Reply bytes go out LSB byte first; NB bytes for READ_REG, 1 byte otherwise.
  - Per byte: wait in SEND until tx_busy=0. Then assert tx_start=1 for one cycle with tx_data valid.
  - Then TX_WAIT: ignore tx_busy for one cycle, then wait for tx_busy=0.
  - After the last byte, return to IDLE.
- Latency: STATUS with idle transmitter gives tx_start 2 cycles after rx_valid (decode, SEND).
- Busy: rx_valid in any state other than IDLE discards the byte and sets cmd_dropped=1. Only reset clears cmd_dropped.
- If wait_for_continue falls during REG_READ, the read still completes and the latched value is sent.
- Simultaneous rx_valid and tx_busy=1 in IDLE: the command is decoded; SEND stalls until tx_busy=0.
- Reset mid-operation (any state): immediate return to reset values; a partially sent reply is abandoned; no further tx_start.
- At most one wait_continue_execution pulse per CONTINUE command; never asserted while debug_get_param=1.

Test Plan:
- Reset, wait_for_continue=0, send 0x01 → one tx_start with tx_data=0x00; no other outputs toggle.
- wait_for_continue=1, debug_data_out=18'h2ABCD, send 0x13 → debug_reg_addr=3, debug_get_param high exactly 2 cycles. Replies 0xCD, 0xAB, 0x02 in order, each tx_start only when tx_busy=0.
- wait_for_continue=1, send 0x02 → wait_continue_execution high exactly 1 cycle, reply 0xAA. Repeat with wait_for_continue=0 → no pulse, reply 0xEE.
- Send 0x18 while wait_for_continue=0 → reply 0xEE, debug_get_param stays 0. Send 0x7F → reply 0xEE.
- During 3-byte reply hold tx_busy=1 for 10 cycles per byte and inject rx_valid with 0x01 → bytes not lost, no extra reply, cmd_dropped=1.
- Assert reset after the first reply byte of READ_REG → all outputs 0 immediately, no further tx_start. A new 0x01 after reset release is answered normally.
